// File: rtl/regfile_dump.sv
// Walks a contiguous register-file range through one async read port and streams
// each word out on valid/ready. Optional XOR checksum enabled by REGDUMP_CHECKSUM_EN.
module regfile_dump #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_read_reg,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              freeze_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              range_err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, ISSUE, SEND, FIN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, last_q_reg;
  logic              out_valid_reg, out_last_reg, range_err_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [ADDR_W-1:0] out_index_reg;

  logic in_idle, do_abort, start_req, start_ok, handshake;

  assign in_idle   = (state_reg == IDLE);
  assign do_abort  = abort && !in_idle;
  // Abort beats start even in IDLE, so a simultaneous pair never launches a dump.
  assign start_req = in_idle && start && !abort;
  assign start_ok  = start_req && (first_reg <= last_reg);
  assign handshake = out_valid_reg && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_ok) state_next = ISSUE;
      ISSUE:   state_next = SEND;
      SEND:    if (handshake) state_next = out_last_reg ? FIN : ISSUE;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (do_abort) state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg       <= '0;
      last_q_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_index_reg <= '0;
      out_last_reg  <= 1'b0;
      range_err_reg <= 1'b0;
    end else begin
      range_err_reg <= 1'b0;
      if (do_abort) begin
        out_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start_ok) begin
              ptr_reg    <= first_reg;
              last_q_reg <= last_reg;
            end else if (start_req) begin
              range_err_reg <= 1'b1;
            end
          end
          ISSUE: begin
            out_data_reg  <= rf_read_data;
            out_index_reg <= ptr_reg;
            out_last_reg  <= (ptr_reg == last_q_reg);
            out_valid_reg <= 1'b1;
          end
          SEND: begin
            if (handshake) begin
              out_valid_reg <= 1'b0;
              // Stopping at the last word keeps ptr from wrapping past index 31.
              if (!out_last_reg) ptr_reg <= ptr_reg + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc_reg, checksum_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg      <= '0;
      checksum_reg <= '0;
    end else if (start_ok) begin
      acc_reg      <= '0;
      checksum_reg <= '0;
    end else if (state_reg == SEND && handshake && !do_abort) begin
      acc_reg <= acc_reg ^ out_data_reg;
      // Publish only the completed fold so consumers never see a partial sum.
      if (out_last_reg) checksum_reg <= acc_reg ^ out_data_reg;
    end
  end

  assign checksum = checksum_reg;
`else
  assign checksum = '0;
`endif

  assign rf_read_reg = ptr_reg;
  assign busy        = !in_idle;
  assign freeze_req  = !in_idle;
  assign done        = (state_reg == FIN);
  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_index   = out_index_reg;
  assign out_last    = out_last_reg;
  assign range_err   = range_err_reg;

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: register file modelled as Rk = k*0x11111111.
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_reg = '0;
  logic [4:0]  last_reg = '0;
  logic        abort = 1'b0;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        freeze_req, out_valid, out_last, busy, done, range_err;
  logic        out_ready = 1'b0;
  logic [31:0] out_data, checksum;
  logic [4:0]  out_index;

  logic [31:0] rf [32];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign rf_read_data = rf[rf_read_reg];

  regfile_dump #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg),
    .last_reg(last_reg), .abort(abort), .rf_read_reg(rf_read_reg),
    .rf_read_data(rf_read_data), .freeze_req(freeze_req), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
    .out_last(out_last), .busy(busy), .done(done), .range_err(range_err),
    .checksum(checksum)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [4:0] idx,
                          input logic lst);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_index"}, {27'd0, out_index}, {27'd0, idx});
    chk({tag, "_last"}, {31'd0, out_last}, {31'd0, lst});
    $display("[TB] %s word idx=%0d data=%h last=%0b", tag, out_index, out_data, out_last);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = k * 32'h11111111;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_freeze", {31'd0, freeze_req}, 32'd0);
    chk("rst_rdreg", {27'd0, rf_read_reg}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cksum", checksum, 32'd0);
    rst_n = 1'b1;
    step();
    $display("[TB] reset released");

    // Basic dump 3..5 with ready high
    out_ready = 1'b1; start = 1'b1; first_reg = 5'd3; last_reg = 5'd5;
    step();
    start = 1'b0;
    chk("b_freeze", {31'd0, freeze_req}, 32'd1);
    chk("b_novalid", {31'd0, out_valid}, 32'd0);
    step(); chk_word("b0", 32'h33333333, 5'd3, 1'b0);
    step(); chk("b0_hs", {31'd0, out_valid}, 32'd0);
    step(); chk_word("b1", 32'h44444444, 5'd4, 1'b0);
    step();
    step(); chk_word("b2", 32'h55555555, 5'd5, 1'b1);
    step();
    chk("b_done", {31'd0, done}, 32'd1);
    chk("b_fin_busy", {31'd0, busy}, 32'd1);
    step();
    chk("b_done_off", {31'd0, done}, 32'd0);
    chk("b_idle", {31'd0, busy}, 32'd0);
`ifdef REGDUMP_CHECKSUM_EN
    chk("b_cksum", checksum, 32'h22222222);
`else
    chk("b_cksum", checksum, 32'd0);
`endif
    $display("[TB] dump 3..5 complete checksum=%h", checksum);

    // Backpressure on word 0 of range 0..1
    out_ready = 1'b0; start = 1'b1; first_reg = 5'd0; last_reg = 5'd1;
    step();
    start = 1'b0;
    step(); chk_word("bp0", 32'h00000000, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_word("bp_hold", 32'h00000000, 5'd0, 1'b0);
      chk("bp_freeze", {31'd0, freeze_req}, 32'd1);
    end
    out_ready = 1'b1;
    step(); chk("bp_hs", {31'd0, out_valid}, 32'd0);
    step(); chk_word("bp1", 32'h11111111, 5'd1, 1'b1);
    step();
    chk("bp_done", {31'd0, done}, 32'd1);
    chk("bp_freeze_fin", {31'd0, freeze_req}, 32'd1);
    step();
    chk("bp_freeze_off", {31'd0, freeze_req}, 32'd0);
    chk("bp_noextra", {31'd0, out_valid}, 32'd0);

    // Range error
    start = 1'b1; first_reg = 5'd9; last_reg = 5'd2;
    step();
    start = 1'b0;
    chk("re_pulse", {31'd0, range_err}, 32'd1);
    chk("re_busy", {31'd0, busy}, 32'd0);
    step();
    chk("re_pulse_off", {31'd0, range_err}, 32'd0);
    chk("re_novalid", {31'd0, out_valid}, 32'd0);
    chk("re_busy2", {31'd0, busy}, 32'd0);
    $display("[TB] range error 9..2 rejected");

    // Boundary 31..31, with a start pulse while busy
    out_ready = 1'b0; start = 1'b1; first_reg = 5'd31; last_reg = 5'd31;
    step();
    first_reg = 5'd0; last_reg = 5'd5;
    step(); chk_word("bd", 32'h1111110F, 5'd31, 1'b1);
    start = 1'b0; out_ready = 1'b1;
    step(); chk("bd_done", {31'd0, done}, 32'd1);
    step();
    chk("bd_idle", {31'd0, busy}, 32'd0);
    chk("bd_novalid", {31'd0, out_valid}, 32'd0);
    step();
    chk("bd_nostart", {31'd0, busy}, 32'd0);

    // Abort while index 4 is presented
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin step(); step(); end
    step(); chk_word("ab", 32'h44444444, 5'd4, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle", {31'd0, busy}, 32'd0);
    chk("ab_novalid", {31'd0, out_valid}, 32'd0);
    chk("ab_nodone", {31'd0, done}, 32'd0);
    step();
    chk("ab_nodone2", {31'd0, done}, 32'd0);
    $display("[TB] abort on index 4 done");

    // Reset mid-dump on index 10
    start = 1'b1; first_reg = 5'd0; last_reg = 5'd31;
    step();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin step(); step(); end
    step(); chk_word("rs", 32'hAAAAAAAA, 5'd10, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_data", out_data, 32'd0);
    chk("rs_index", {27'd0, out_index}, 32'd0);
    chk("rs_rdreg", {27'd0, rf_read_reg}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    #10 rst_n = 1'b1;
    step();
    chk("rs_after", {31'd0, busy}, 32'd0);
    $display("[TB] async reset mid-dump done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
